norm_shift_unit: RTL and testbench
==================================

// Module: norm_shift_unit
// PURPOSE
//   Multi-cycle normalizer for the KGP miniRISC execute stage. It recovers the
//   left-shift amount that normalizes an operand (count-leading-zeros / -sign-bits).
//   It also returns the normalized value, one bit position per cycle.
//   The ALU starts it with a start/done handshake. Results feed the writeback mux.
// PARAMETERS
//   WIDTH  32  operand width in bits
//   SHW    5   shift-count width, clog2(WIDTH)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active-low (rst==0 resets)
//   start     in   1      request; sampled only when busy==0
//   in        in   WIDTH  operand, captured on an accepted start
//   mode      in   1      0 = unsigned (count leading 0s), 1 = signed (count redundant sign bits)
//   busy      out  1      high from the cycle after an accepted start until done
//   done      out  1      one-cycle pulse: results valid
//   norm_val  out  WIDTH  normalized operand; held until the next done
//   shamt     out  SHW    left-shift count applied
//   zero_flag out  1      operand carries no information (see below); held with results
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, norm_val=0, shamt=0, zero_flag=0; internal regs cleared.
//   Reset mid-operation aborts the operation immediately. No done is produced for it.
//   States:
//     IDLE  : if start, capture in->acc, mode->md, cnt=0; go SHIFT.
//     SHIFT : busy=1. Each cycle evaluate term:
//             md=0: term = acc[W-1]==1
//             md=1: term = acc[W-1]!=acc[W-2]
//             term || zero || cnt==W-1 -> latch outputs, done=1, go IDLE.
//             otherwise acc<=acc<<1 (zero fill), cnt<=cnt+1.
//   Zero / degenerate case:
//     md=0 with acc==0, or md=1 with acc all-0s or all-1s.
//     Detected in the first SHIFT cycle.
//     Result: zero_flag=1, norm_val=captured in, shamt=0.
//   Latency: done rises on the (2+shamt)-th rising edge after the accepted start edge.
//     Minimum 2 cycles; maximum 2+(W-1)=33 cycles for W=32.
//   Saturation: cnt never wraps. cnt==W-1 forces termination.
//     This is reachable only for md=0, in=1: shamt=31, norm_val=0x80000000.
//   Handshake:
//     start while busy==1 is ignored; no queuing; in/mode changes do not affect the op.
//     done is high in the first IDLE cycle after SHIFT.
//     A start in that same cycle is accepted; done still pulses only one cycle.
//   Outputs:
//     norm_val, shamt and zero_flag update only on the done edge.
//     They are stable otherwise, including while busy.
//   Invariant: !zero_flag -> norm_val == in << shamt (WIDTH bits).
//     md=1 also preserves the sign: norm_val[W-1]==in[W-1].
// TESTING
//   1. md=0, in=0x80000000 -> done 2 cycles after start; shamt=0, norm_val=0x80000000, zero_flag=0.
//   2. md=0, in=0x00000001 -> done after 33 cycles; shamt=31, norm_val=0x80000000; busy high 32 cycles.
//   3. md=1, in=0xFFFF0F00 -> shamt=15, norm_val=0x87800000.
//      md=1, in=0x00001234 -> shamt=18, norm_val=0x48D00000.
//   4. md=0, in=0 -> zero_flag=1, shamt=0, norm_val=0, done at cycle 2.
//      md=1, in=0xFFFFFFFF -> zero_flag=1, norm_val=0xFFFFFFFF.
//   5. Pulse start with in=0x1 while busy -> ignored, first op's results unchanged.
//      Start on the done cycle -> second op accepted, two distinct done pulses.
//   6. Assert rst low mid-SHIFT -> all outputs 0 at once, no done.
//      Release rst, start md=0, in=0x00F00000 -> shamt=8, norm_val=0xF0000000.

Source files
------------

// File: rtl/norm_shift_unit.sv
// ---------------------------------------------------------------------------
// norm_shift_unit
//   Multi-cycle normalizer for the execute stage. It finds the left-shift
//   amount that normalizes an operand. In unsigned mode that amount is the
//   number of leading zeros. In signed mode it is the number of redundant sign
//   bits. The normalized value is produced by shifting one position per cycle.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active-low
//   start     : request, sampled only while idle
//   in        : operand, captured on an accepted start
//   mode      : 0 = count leading zeros, 1 = count redundant sign bits
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse, results valid
//   norm_val  : normalized operand, held until the next done
//   shamt     : left-shift count that was applied
//   zero_flag : operand was degenerate (all zeros / all sign bits)
// ---------------------------------------------------------------------------
module norm_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm_val,
  output logic [SHW-1:0]   shamt,
  output logic             zero_flag
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic             md_r;
  logic [SHW-1:0]   cnt_r;

  logic             term_s;
  logic             zero_s;
  logic             last_s;
  logic             finish_s;

  // An operand is degenerate when no shift can normalize it: all zeros in
  // unsigned mode, or a value made only of sign bits in signed mode.
  function automatic logic is_degenerate(input logic [WIDTH-1:0] v, input logic m);
    logic r;
    if (m == 1'b0) begin
      r = (v == {WIDTH{1'b0}});
    end else begin
      r = (v == {WIDTH{1'b0}}) || (v == {WIDTH{1'b1}});
    end
    return r;
  endfunction

  // Termination conditions for the current shift step.
  always_comb begin
    term_s   = 1'b0;
    zero_s   = 1'b0;
    last_s   = 1'b0;
    finish_s = 1'b0;
    if (md_r == 1'b0) begin
      term_s = acc_r[WIDTH-1];
    end else begin
      term_s = acc_r[WIDTH-1] ^ acc_r[WIDTH-2];
    end
    // A degenerate operand is recognised only on the first step. At that
    // step acc_r still holds the captured operand.
    if (cnt_r == {SHW{1'b0}}) begin
      zero_s = is_degenerate(acc_r, md_r);
    end else begin
      zero_s = 1'b0;
    end
    // The counter saturates at WIDTH-1 instead of wrapping.
    last_s   = (cnt_r == SHW'(WIDTH - 1));
    finish_s = term_s || zero_s || last_s;
  end

  // Control FSM with shift datapath. All outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      acc_r     <= {WIDTH{1'b0}};
      md_r      <= 1'b0;
      cnt_r     <= {SHW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      norm_val  <= {WIDTH{1'b0}};
      shamt     <= {SHW{1'b0}};
      zero_flag <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc_r   <= in;
            md_r    <= mode;
            cnt_r   <= {SHW{1'b0}};
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (finish_s) begin
            // On a degenerate operand, acc_r is still the untouched operand
            // and cnt_r is zero, so the same latch works for both outcomes.
            norm_val  <= acc_r;
            shamt     <= cnt_r;
            zero_flag <= zero_s;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            acc_r   <= {acc_r[WIDTH-2:0], 1'b0};
            cnt_r   <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_shift_unit.sv
module tb_norm_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_in;
  logic        op_mode;
  logic        busy;
  logic        done;
  logic [31:0] norm_val;
  logic [4:0]  shamt;
  logic        zero_flag;

  int n_checks = 0;
  int n_fail   = 0;

  norm_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (op_in),
    .mode      (op_mode),
    .busy      (busy),
    .done      (done),
    .norm_val  (norm_val),
    .shamt     (shamt),
    .zero_flag (zero_flag)
  );

  always #5 clk = ~clk;

  // Start one operation and wait for done.
  // edges counts rising edges from the accepting edge (edge 1) to the done edge.
  task automatic run_op(input logic [31:0] v, input logic m, output int edges, output int busy_cnt);
    @(negedge clk);
    op_in = v; op_mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL op_timeout in=%h mode=%0d: done=%b after %0d edges, required 1", v, m, done, edges);
    end
  endtask

  task automatic check_result(input string name, input int edges, input logic [31:0] exp_nv,
                              input logic [4:0] exp_sh, input logic exp_z);
    n_checks++;
    if (norm_val !== exp_nv) begin
      n_fail++; $display("FAIL %s norm_val: got %h required %h", name, norm_val, exp_nv);
    end
    n_checks++;
    if (shamt !== exp_sh) begin
      n_fail++; $display("FAIL %s shamt: got %0d required %0d", name, shamt, exp_sh);
    end
    n_checks++;
    if (zero_flag !== exp_z) begin
      n_fail++; $display("FAIL %s zero_flag: got %b required %b", name, zero_flag, exp_z);
    end
    n_checks++;
    if (edges != 2 + int'(exp_sh)) begin
      n_fail++; $display("FAIL %s latency: got %0d edges required %0d", name, edges, 2 + int'(exp_sh));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op_in = 32'h0; op_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, norm_val, shamt, zero_flag} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b nv=%h sh=%0d z=%b required all 0",
               busy, done, norm_val, shamt, zero_flag);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int e, b;
    run_op(32'h8000_0000, 1'b0, e, b);
    check_result("u_msb", e, 32'h8000_0000, 5'd0, 1'b0);
    run_op(32'h0000_0001, 1'b0, e, b);
    check_result("u_sat", e, 32'h8000_0000, 5'd31, 1'b0);
    n_checks++;
    if (b != 32) begin
      n_fail++; $display("FAIL u_sat busy_cycles: got %0d required 32", b);
    end
    run_op(32'h0000_5000, 1'b0, e, b);
    check_result("u_mid", e, 32'hA000_0000, 5'd17, 1'b0);
  endtask

  task automatic test_signed();
    int e, b;
    run_op(32'hFFFF_0F00, 1'b1, e, b);
    check_result("s_neg", e, 32'h8780_0000, 5'd15, 1'b0);
    run_op(32'h0000_1234, 1'b1, e, b);
    check_result("s_pos", e, 32'h48D0_0000, 5'd18, 1'b0);
    run_op(32'h4000_0000, 1'b1, e, b);
    check_result("s_norm", e, 32'h4000_0000, 5'd0, 1'b0);
    run_op(32'hFFFF_FFFE, 1'b1, e, b);
    check_result("s_m2", e, 32'h8000_0000, 5'd30, 1'b0);
  endtask

  task automatic test_zero();
    int e, b;
    run_op(32'h0000_0000, 1'b0, e, b);
    check_result("z_u0", e, 32'h0000_0000, 5'd0, 1'b1);
    run_op(32'hFFFF_FFFF, 1'b1, e, b);
    check_result("z_s1", e, 32'hFFFF_FFFF, 5'd0, 1'b1);
    run_op(32'h0000_0000, 1'b1, e, b);
    check_result("z_s0", e, 32'h0000_0000, 5'd0, 1'b1);
    run_op(32'hFFFF_FFFF, 1'b0, e, b);
    check_result("z_clr", e, 32'hFFFF_FFFF, 5'd0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int e;
    @(negedge clk);
    op_in = 32'h0001_0000; op_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; e = 1;
    repeat (3) begin @(posedge clk); #1; e++; end
    // Previous results must stay put while busy.
    n_checks++;
    if (busy !== 1'b1 || norm_val !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL hold_while_busy: got busy=%b nv=%h required 1 ffffffff", busy, norm_val);
    end
    @(negedge clk); op_in = 32'h0000_0001; start = 1'b1;
    @(negedge clk); start = 1'b0; op_in = 32'hDEAD_BEEF; op_mode = 1'b1;
    e = e + 1;
    while (!done && e < 40) begin @(posedge clk); #1; e++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL ign_timeout: done=%b required 1", done);
    end
    check_result("ign", e, 32'h8000_0000, 5'd15, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL ign_no_queue: got busy=%b done=%b required 0 0", busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, b;
    run_op(32'h4000_0000, 1'b0, e, b);
    check_result("b2b_first", e, 32'h8000_0000, 5'd1, 1'b0);
    // Still inside the done cycle: request the next operation now.
    op_in = 32'h0000_0300; op_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; e = 1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got done=%b busy=%b required 0 1", done, busy);
    end
    n_checks++;
    if (norm_val !== 32'h8000_0000 || shamt !== 5'd1) begin
      n_fail++; $display("FAIL b2b_hold: got nv=%h sh=%0d required 80000000 1", norm_val, shamt);
    end
    while (!done && e < 40) begin @(posedge clk); #1; e++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_timeout: done=%b required 1", done);
    end
    check_result("b2b_second", e, 32'hC000_0000, 5'd22, 1'b0);
  endtask

  task automatic test_reset_mid();
    int e, b;
    @(negedge clk);
    op_in = 32'h0000_0001; op_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_busy: got %b required 1", busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, norm_val, shamt, zero_flag} !== 40'h0) begin
      n_fail++;
      $display("FAIL rst_async: got busy=%b done=%b nv=%h sh=%0d z=%b required all 0",
               busy, done, norm_val, shamt, zero_flag);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_done: got done=%b busy=%b required 0 0", done, busy);
      end
    end
    @(negedge clk); rst = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL rst_aborted_done: got %b required 0", done);
      end
    end
    run_op(32'h00F0_0000, 1'b0, e, b);
    check_result("rst_after", e, 32'hF000_0000, 5'd8, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
